// File: rtl/otp_macro_seq.sv
// Command sequencer in front of the OTP macro ready/valid port.
// Optional watchdog enabled by defining OTP_MACRO_SEQ_TIMEOUT_EN.
module otp_macro_seq #(
    parameter int Width         = 16,
    parameter int SizeWidth     = 2,
    parameter int AddrWidth     = 10,
    parameter int ErrWidth      = 3,
    parameter int TimeoutCycles = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             init_req_i,
    output logic                             init_done_o,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic                             req_write_i,
    input  logic [AddrWidth-1:0]             req_addr_i,
    input  logic [SizeWidth-1:0]             req_size_i,
    input  logic [(2**SizeWidth)*Width-1:0]  req_wdata_i,
    output logic                             rsp_valid_o,
    output logic [(2**SizeWidth)*Width-1:0]  rsp_rdata_o,
    output logic [ErrWidth-1:0]              rsp_err_o,
    output logic                             busy_o,
    output logic                             otp_valid_o,
    input  logic                             otp_ready_i,
    output logic [1:0]                       otp_cmd_o,
    output logic [SizeWidth-1:0]             otp_size_o,
    output logic [AddrWidth-1:0]             otp_addr_o,
    output logic [(2**SizeWidth)*Width-1:0]  otp_wdata_o,
    input  logic                             otp_rvalid_i,
    input  logic [(2**SizeWidth)*Width-1:0]  otp_rdata_i,
    input  logic [ErrWidth-1:0]              otp_err_i
);

    localparam int IfW = (2**SizeWidth) * Width;
    localparam logic [ErrWidth-1:0] TimeoutErr = '1;

    typedef enum logic [2:0] {
        ResetSt,
        InitCmdSt,
        InitWaitSt,
        IdleSt,
        CmdSt,
        WaitSt,
        ErrSt
    } state_e;

    state_e state_q, state_d;

    logic                 wr_q;
    logic [AddrWidth-1:0] addr_q;
    logic [SizeWidth-1:0] size_q;
    logic [IfW-1:0]       wdata_q;
    logic [ErrWidth-1:0]  err_q;
    logic                 done_q;
    logic                 rsp_valid_q;
    logic [IfW-1:0]       rsp_rdata_q;
    logic [ErrWidth-1:0]  rsp_err_q;
    logic                 timeout;

`ifdef OTP_MACRO_SEQ_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles) + 1;

    logic [CntW-1:0] cnt_q;
    logic            waiting;

    assign waiting = (state_q == InitWaitSt) || (state_q == WaitSt);

    // Watchdog: zero outside the wait states, saturating count inside them
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (!waiting) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A response arriving in the expiry cycle takes priority
    assign timeout = waiting && !otp_rvalid_i &&
                     (cnt_q == CntW'(TimeoutCycles - 1));
`else
    logic unused_timeout;

    assign unused_timeout = ^TimeoutCycles;
    assign timeout        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ResetSt;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and macro/client handshake outputs
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        otp_valid_o = 1'b0;
        otp_cmd_o   = 2'b00;
        otp_size_o  = '0;
        otp_addr_o  = '0;
        otp_wdata_o = '0;
        unique case (state_q)
            ResetSt: begin
                if (init_req_i) state_d = InitCmdSt;
            end
            InitCmdSt: begin
                otp_valid_o = 1'b1;
                otp_cmd_o   = 2'b11;
                if (otp_ready_i) state_d = InitWaitSt;
            end
            InitWaitSt: begin
                if (otp_rvalid_i) begin
                    state_d = (otp_err_i == '0) ? IdleSt : ErrSt;
                end else if (timeout) begin
                    state_d = ErrSt;
                end
            end
            IdleSt: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = CmdSt;
            end
            CmdSt: begin
                otp_valid_o = 1'b1;
                otp_cmd_o   = {1'b0, wr_q};
                otp_size_o  = size_q;
                otp_addr_o  = addr_q;
                otp_wdata_o = wdata_q;
                if (otp_ready_i) state_d = WaitSt;
            end
            WaitSt: begin
                if (otp_rvalid_i) begin
                    state_d = IdleSt;
                end else if (timeout) begin
                    state_d = ErrSt;
                end
            end
            ErrSt: begin
                req_ready_o = 1'b1;
            end
            default: state_d = ResetSt;
        endcase
    end

    // Request capture, init status and latched error code
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            if (state_q == IdleSt && req_valid_i) begin
                wr_q    <= req_write_i;
                addr_q  <= req_addr_i;
                size_q  <= req_size_i;
                wdata_q <= req_wdata_i;
            end
            if (state_q == InitWaitSt && otp_rvalid_i) begin
                done_q <= (otp_err_i == '0);
                err_q  <= otp_err_i;
            end
            if (timeout) begin
                done_q <= 1'b0;
                err_q  <= TimeoutErr;
            end
        end
    end

    // Registered one-cycle client response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= '0;
            if (state_q == WaitSt && otp_rvalid_i) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= otp_err_i;
                if (!wr_q && otp_err_i == '0) begin
                    rsp_rdata_q <= otp_rdata_i;
                end
            end else if (state_q == WaitSt && timeout) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= TimeoutErr;
            end else if (state_q == ErrSt && req_valid_i) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err_q;
            end
        end
    end

    assign init_done_o = done_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = !(state_q inside {ResetSt, IdleSt, ErrSt});

endmodule

// File: tb/tb_otp_macro_seq.sv
// Bench for otp_macro_seq: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_otp_macro_seq;

    localparam int W   = 16;
    localparam int SW  = 2;
    localparam int AW  = 10;
    localparam int EW  = 3;
    localparam int TO  = 16;
    localparam int IFW = (2**SW) * W;
`ifdef OTP_MACRO_SEQ_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           init_req = 1'b0;
    logic           init_done;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_write = 1'b0;
    logic [AW-1:0]  req_addr = '0;
    logic [SW-1:0]  req_size = '0;
    logic [IFW-1:0] req_wdata = '0;
    logic           rsp_valid;
    logic [IFW-1:0] rsp_rdata;
    logic [EW-1:0]  rsp_err;
    logic           busy;
    logic           otp_valid;
    logic           otp_ready = 1'b0;
    logic [1:0]     otp_cmd;
    logic [SW-1:0]  otp_size;
    logic [AW-1:0]  otp_addr;
    logic [IFW-1:0] otp_wdata;
    logic           otp_rvalid = 1'b0;
    logic [IFW-1:0] otp_rdata = '0;
    logic [EW-1:0]  otp_err = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    otp_macro_seq #(
        .Width(W), .SizeWidth(SW), .AddrWidth(AW),
        .ErrWidth(EW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .init_req_i(init_req), .init_done_o(init_done),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_addr_i(req_addr),
        .req_size_i(req_size), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .busy_o(busy),
        .otp_valid_o(otp_valid), .otp_ready_i(otp_ready),
        .otp_cmd_o(otp_cmd), .otp_size_o(otp_size),
        .otp_addr_o(otp_addr), .otp_wdata_o(otp_wdata),
        .otp_rvalid_i(otp_rvalid), .otp_rdata_i(otp_rdata),
        .otp_err_i(otp_err)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Transaction-level model: what is outstanding, not how it is encoded
    bit             m_armed = 1'b1;
    bit             m_inited = 1'b0;
    bit             m_dead = 1'b0;
    bit             m_issue = 1'b0;
    bit             m_wait = 1'b0;
    bit             m_wait_init = 1'b0;
    bit             m_write = 1'b0;
    logic [1:0]     m_cmd = '0;
    logic [AW-1:0]  m_addr = '0;
    logic [SW-1:0]  m_size = '0;
    logic [IFW-1:0] m_wdata = '0;
    logic [EW-1:0]  m_err = '0;
    int             m_cnt = 0;
    bit             m_rv = 1'b0;
    logic [IFW-1:0] m_rd = '0;
    logic [EW-1:0]  m_re = '0;

    // Inputs change only at negedge+1, so here they equal the values
    // the DUT sampled at the preceding posedge.
    always @(negedge clk) begin : model_cmp
        bit rdy;
        rdy  = !m_issue && !m_wait && (m_inited || m_dead);
        m_rv = 1'b0;
        m_rd = '0;
        m_re = '0;
        if (rst) begin
            m_armed  = 1'b1;
            m_inited = 1'b0;
            m_dead   = 1'b0;
            m_issue  = 1'b0;
            m_wait   = 1'b0;
            m_err    = '0;
        end else if (m_armed) begin
            if (init_req) begin
                m_armed     = 1'b0;
                m_issue     = 1'b1;
                m_wait_init = 1'b1;
                m_cmd       = 2'b11;
                m_addr      = '0;
                m_size      = '0;
                m_wdata     = '0;
            end
        end else if (m_issue) begin
            if (otp_ready) begin
                m_issue = 1'b0;
                m_wait  = 1'b1;
                m_cnt   = 0;
            end
        end else if (m_wait) begin
            if (otp_rvalid) begin
                m_wait = 1'b0;
                if (m_wait_init) begin
                    if (otp_err == 0) m_inited = 1'b1;
                    else begin
                        m_dead = 1'b1;
                        m_err  = otp_err;
                    end
                end else begin
                    m_rv = 1'b1;
                    m_re = otp_err;
                    m_rd = (!m_write && otp_err == 0) ? otp_rdata : '0;
                end
            end else if (TimeoutOn && m_cnt == TO - 1) begin
                m_wait = 1'b0;
                m_dead = 1'b1;
                m_err  = 3'h7;
                if (!m_wait_init) begin
                    m_rv = 1'b1;
                    m_re = 3'h7;
                end
            end else begin
                m_cnt++;
            end
        end else if (rdy && req_valid) begin
            if (m_dead) begin
                m_rv = 1'b1;
                m_re = m_err;
            end else begin
                m_issue     = 1'b1;
                m_wait_init = 1'b0;
                m_write     = req_write;
                m_cmd       = req_write ? 2'b01 : 2'b00;
                m_addr      = req_addr;
                m_size      = req_size;
                m_wdata     = req_wdata;
            end
        end
        chk("m_rsp_valid", rsp_valid, m_rv);
        if (m_rv) begin
            chk("m_rsp_rdata", rsp_rdata, m_rd);
            chk("m_rsp_err", rsp_err, m_re);
        end
        chk("m_otp_valid", otp_valid, m_issue);
        chk("m_otp_cmd", otp_cmd, m_issue ? m_cmd : 2'b00);
        chk("m_otp_addr", otp_addr, m_issue ? m_addr : '0);
        chk("m_otp_size", otp_size, m_issue ? m_size : '0);
        chk("m_otp_wdata", otp_wdata, m_issue ? m_wdata : '0);
        chk("m_req_ready", req_ready,
            !m_issue && !m_wait && (m_inited || m_dead));
        chk("m_busy", busy, m_issue || m_wait);
        chk("m_init_done", init_done, m_inited && !m_dead);
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        init_req = 1'b0;
        req_valid = 1'b0;
        otp_ready = 1'b0;
        otp_rvalid = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc();
    endtask

    task automatic do_init(input logic [EW-1:0] e, input bit exp_done);
        init_req = 1'b1;
        otp_ready = 1'b1;
        cyc();
        chk("init_valid", otp_valid, 1);
        chk("init_cmd", otp_cmd, 2'b11);
        init_req = 1'b0;
        cyc();
        chk("init_cmd_once", otp_valid, 0);
        otp_ready = 1'b0;
        cyc(2);
        otp_rvalid = 1'b1;
        otp_err = e;
        cyc();
        otp_rvalid = 1'b0;
        otp_err = '0;
        chk("init_done", init_done, exp_done);
    endtask

    task automatic do_req(input bit wr, input logic [AW-1:0] a,
                          input logic [SW-1:0] s, input logic [IFW-1:0] wd,
                          input int rdly, input int vdly,
                          input logic [IFW-1:0] mrd, input logic [EW-1:0] me,
                          input logic [IFW-1:0] xrd, input logic [EW-1:0] xe);
        req_valid = 1'b1;
        req_write = wr;
        req_addr = a;
        req_size = s;
        req_wdata = wd;
        cyc();
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr = ~a;
        req_size = ~s;
        req_wdata = ~wd;
        chk("cmd_valid", otp_valid, 1);
        chk("cmd_code", otp_cmd, {1'b0, wr});
        chk("cmd_addr", otp_addr, a);
        chk("cmd_size", otp_size, s);
        chk("cmd_wdata", otp_wdata, wd);
        repeat (rdly) begin
            cyc();
            chk("hold_valid", otp_valid, 1);
            chk("hold_addr", otp_addr, a);
            chk("hold_size", otp_size, s);
            chk("hold_wdata", otp_wdata, wd);
        end
        otp_ready = 1'b1;
        cyc();
        otp_ready = 1'b0;
        chk("cmd_done", otp_valid, 0);
        cyc(vdly);
        chk("no_early_rsp", rsp_valid, 0);
        otp_rvalid = 1'b1;
        otp_rdata = mrd;
        otp_err = me;
        cyc();
        otp_rvalid = 1'b0;
        otp_rdata = '1;
        otp_err = '0;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, xrd);
        chk("rsp_err", rsp_err, xe);
        cyc();
        chk("rsp_pulse", rsp_valid, 0);
    endtask

    initial begin
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", otp_valid, 0);
        chk("rst_done", init_done, 0);

        do_init(3'h0, 1'b1);
        chk("idle_ready", req_ready, 1);

        do_req(1'b0, 10'h010, 2'd3, 64'h0, 0, 1,
               64'h0004_0003_0002_0001, 3'h0,
               64'h0004_0003_0002_0001, 3'h0);
        do_req(1'b1, 10'h155, 2'd0, 64'hBEEF, 4, 2,
               64'hDEAD_BEEF_0000_1111, 3'h0, 64'h0, 3'h0);
        do_req(1'b1, 10'h3FF, 2'd1, 64'h1234_5678, 0, 0,
               64'h0000_0000_0000_00FF, 3'h5, 64'h0, 3'h5);
        do_req(1'b0, 10'h020, 2'd2, 64'h0, 1, 3,
               64'hAAAA_5555_AAAA_5555, 3'h2, 64'h0, 3'h2);
        chk("idle_after_err", req_ready, 1);

        otp_rvalid = 1'b1;
        otp_rdata = 64'h77;
        init_req = 1'b1;
        cyc();
        otp_rvalid = 1'b0;
        init_req = 1'b0;
        chk("stray_rvalid", rsp_valid, 0);
        chk("stray_init", busy, 0);

        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 10'h0AA;
        cyc();
        req_valid = 1'b0;
        otp_ready = 1'b1;
        cyc();
        otp_ready = 1'b0;
        chk("wait_busy", busy, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        otp_rvalid = 1'b1;
        otp_rdata = 64'h1;
        cyc();
        otp_rvalid = 1'b0;
        chk("stale_rsp", rsp_valid, 0);
        chk("stale_done", init_done, 0);
        chk("stale_busy", busy, 0);
        cyc();
        chk("stale_rsp2", rsp_valid, 0);

        do_init(3'h4, 1'b0);
        chk("err_ready", req_ready, 1);
        chk("err_busy", busy, 0);
        req_valid = 1'b1;
        cyc();
        chk("err_rsp_a", rsp_valid, 1);
        chk("err_code_a", rsp_err, 3'h4);
        chk("err_rdata_a", rsp_rdata, 0);
        cyc();
        req_valid = 1'b0;
        chk("err_rsp_b", rsp_valid, 1);
        chk("err_code_b", rsp_err, 3'h4);
        cyc();
        chk("err_rsp_end", rsp_valid, 0);

`ifdef OTP_MACRO_SEQ_TIMEOUT_EN
        do_reset();
        do_init(3'h0, 1'b1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 10'h001;
        cyc();
        req_valid = 1'b0;
        otp_ready = 1'b1;
        cyc();
        otp_ready = 1'b0;
        chk("to_c1", rsp_valid, 0);
        for (int i = 2; i <= 16; i++) begin
            cyc();
            chk("to_quiet", rsp_valid, 0);
        end
        cyc();
        chk("to_rsp", rsp_valid, 1);
        chk("to_err", rsp_err, 3'h7);
        chk("to_rdata", rsp_rdata, 0);
        chk("to_done", init_done, 0);
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("to_late_rsp", rsp_valid, 1);
        chk("to_late_err", rsp_err, 3'h7);
        cyc();
`endif

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
